// File: rtl/tdes_pkg.sv
// Shared types and constants for the iterative DES/TDES round sequencer.
// The state enum and key encodings are used by the sequencer and its key-order map.
package tdes_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ROUND   = 3'd1,
      CAPTURE = 3'd2,
      FEED    = 3'd3,
      DONE    = 3'd4
   } seq_state_t;

   localparam logic [1:0] KEY_K1 = 2'd0;
   localparam logic [1:0] KEY_K2 = 2'd1;
   localparam logic [1:0] KEY_K3 = 2'd2;

   localparam int NUM_ROUNDS_DES  = 16;
   localparam int NUM_PASSES_TDES = 3;

   // True when the pass just finished is the final one for this block.
   function automatic logic is_last_pass(input logic [1:0] pass, input logic tdes);
      return (~tdes) | (pass == 2'(NUM_PASSES_TDES - 1));
   endfunction

endpackage

// File: rtl/tdes_round_sequencer_if.sv
// Host/datapath handshake bundle for the round sequencer.
// slave = sequencer side, master = host/datapath side.
interface tdes_round_sequencer_if #(parameter int RIDX_W = 4);
   logic              pt_valid;
   logic              pt_ready;
   logic              tdes_en;
   logic              decrypt;
   logic              load_new_pt;
   logic              output_ok;
   logic              pt_src_sel;
   logic [RIDX_W-1:0] round_idx;
   logic [1:0]        key_sel;
   logic              key_dec;
   logic              ct_valid;
   logic              ct_ready;
   logic              busy;

   modport slave (
      input  pt_valid, tdes_en, decrypt, ct_ready,
      output pt_ready, load_new_pt, output_ok, pt_src_sel,
             round_idx, key_sel, key_dec, ct_valid, busy
   );

   modport master (
      output pt_valid, tdes_en, decrypt, ct_ready,
      input  pt_ready, load_new_pt, output_ok, pt_src_sel,
             round_idx, key_sel, key_dec, ct_valid, busy
   );
endinterface

// File: rtl/tdes_key_order.sv
// Maps the current pass and mode to the key select and schedule direction.
// TDES encrypt runs K1/enc, K2/dec, K3/enc; decrypt runs K3/dec, K2/enc, K1/dec.
module tdes_key_order
   import tdes_pkg::*;
(
   input  logic [1:0] pass,
   input  logic       tdes_en,
   input  logic       decrypt,
   output logic [1:0] key_sel,
   output logic       key_dec
);

   // Key/direction lookup for each pass.
   always_comb begin
      key_sel = KEY_K1;
      key_dec = 1'b0;
      if (!tdes_en) begin
         key_sel = KEY_K1;
         key_dec = decrypt;
      end else begin
         case (pass)
            2'd0: begin
               key_sel = decrypt ? KEY_K3 : KEY_K1;
               key_dec = decrypt;
            end
            2'd1: begin
               key_sel = KEY_K2;
               key_dec = ~decrypt;
            end
            2'd2: begin
               key_sel = decrypt ? KEY_K1 : KEY_K3;
               key_dec = decrypt;
            end
            default: begin
               key_sel = KEY_K1;
               key_dec = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/tdes_round_sequencer.sv
// Control FSM for an iterative DES round datapath: 16 rounds per pass,
// optional three-pass TDES chaining, and valid/ready handshakes on both ends.
module tdes_round_sequencer
   import tdes_pkg::*;
#(
   parameter int NUM_ROUNDS = NUM_ROUNDS_DES,
   parameter int RIDX_W     = 4
)(
   input  logic                  clk,
   input  logic                  reset,
   tdes_round_sequencer_if.slave bus
);

   seq_state_t        state_r, state_s;
   logic [1:0]        pass_r;
   logic [RIDX_W-1:0] cnt_r;
   logic              tdes_r, dec_r;

   logic              accept_s, last_round_s, last_pass_s;
   logic [1:0]        ko_pass_s, ko_sel_s;
   logic              ko_tdes_s, ko_dec_in_s, ko_dec_s, key_valid_s;

   assign accept_s     = (state_r == IDLE) & ~reset & bus.pt_valid;
   assign last_round_s = (cnt_r == RIDX_W'(NUM_ROUNDS - 1));
   assign last_pass_s  = is_last_pass(pass_r, tdes_r);

   // The accept cycle is already round 1, so keys come from the live mode inputs there.
   assign ko_pass_s   = (state_r == IDLE) ? 2'd0 : pass_r;
   assign ko_tdes_s   = (state_r == IDLE) ? bus.tdes_en : tdes_r;
   assign ko_dec_in_s = (state_r == IDLE) ? bus.decrypt : dec_r;

   tdes_key_order u_key_order (
      .pass    (ko_pass_s),
      .tdes_en (ko_tdes_s),
      .decrypt (ko_dec_in_s),
      .key_sel (ko_sel_s),
      .key_dec (ko_dec_s)
   );

   // State register plus pass/round counters and the mode latched on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         pass_r  <= 2'd0;
         cnt_r   <= '0;
         tdes_r  <= 1'b0;
         dec_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  tdes_r <= bus.tdes_en;
                  dec_r  <= bus.decrypt;
                  pass_r <= 2'd0;
                  cnt_r  <= RIDX_W'(1);
               end
            end
            ROUND:   cnt_r <= last_round_s ? '0 : cnt_r + RIDX_W'(1);
            CAPTURE: begin
               cnt_r <= '0;
               if (!last_pass_s) begin
                  pass_r <= pass_r + 2'd1;
               end
            end
            FEED:    cnt_r <= RIDX_W'(1);
            DONE: begin
               if (bus.ct_ready) begin
                  pass_r <= 2'd0;
               end
            end
            default: cnt_r <= '0;
         endcase
      end
   end

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    state_s = accept_s ? ROUND : IDLE;
         ROUND:   state_s = last_round_s ? CAPTURE : ROUND;
         CAPTURE: state_s = last_pass_s ? DONE : FEED;
         FEED:    state_s = ROUND;
         DONE:    state_s = bus.ct_ready ? IDLE : DONE;
         default: state_s = IDLE;
      endcase
   end

   // Datapath strobes and host handshake outputs.
   always_comb begin
      bus.pt_ready    = (state_r == IDLE) & ~reset;
      bus.load_new_pt = accept_s | (state_r == FEED);
      bus.output_ok   = (state_r == CAPTURE);
      bus.pt_src_sel  = (state_r == FEED);
      bus.round_idx   = (state_r == ROUND) ? cnt_r : '0;
      bus.ct_valid    = (state_r == DONE);
      bus.busy        = (state_r != IDLE);
      key_valid_s     = bus.load_new_pt | (state_r == ROUND) | (state_r == CAPTURE);
      if (key_valid_s) begin
         bus.key_sel = ko_sel_s;
         bus.key_dec = ko_dec_s;
      end else begin
         bus.key_sel = KEY_K1;
         bus.key_dec = 1'b0;
      end
   end

endmodule
